// File: rtl/bcd_to_decimal_decoder_stream.sv
// Streaming BCD digit decoder: each accepted 4-bit code becomes an 11-bit {err, one-hot}
// entry in a first-word-fall-through FIFO, with a saturating count of invalid codes.
module bcd_to_decimal_decoder_stream #(
    parameter int DEPTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [3:0]                in_bcd,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [9:0]                out_d,
    output logic                      out_err,
    output logic [$clog2(DEPTH):0]    level,
    output logic [ERR_CNT_W-1:0]      err_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [10:0]          mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [9:0]  dec_onehot;
    logic        dec_err;
    logic [10:0] head;
    logic        push;
    logic        pop;

    always_comb begin
        dec_onehot = '0;
        dec_err    = 1'b0;
        if (in_bcd <= 4'd9) begin
            dec_onehot = 10'b1 << in_bcd;
        end else begin
            dec_err = 1'b1;
        end
    end

    // Full blocks pushes outright, even when a pop happens in the same cycle.
    assign in_ready  = (level_q != FULL_LVL);
    assign out_valid = (level_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        err_cnt_d = err_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        if (push && dec_err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Storage needs no reset; empty-state outputs are forced to zero below.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= {dec_err, dec_onehot};
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign out_d     = out_valid ? head[9:0] : 10'b0;
    assign out_err   = out_valid ? head[10]  : 1'b0;
    assign level     = level_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_bcd_to_decimal_decoder_stream.sv
// Directed plus randomized bench against a queue-based reference of the decoding FIFO.
module tb_bcd_to_decimal_decoder_stream;

    localparam int DEPTH     = 4;
    localparam int ERR_CNT_W = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_bcd;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_d;
    logic        out_err;
    logic [2:0]  level;
    logic [ERR_CNT_W-1:0] err_count;

    int checks = 0;
    int errors = 0;

    int q[$];
    int errc = 0;
    int err_max = (1 << ERR_CNT_W) - 1;

    bcd_to_decimal_decoder_stream #(.DEPTH(DEPTH), .ERR_CNT_W(ERR_CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_d     (out_d),
        .out_err   (out_err),
        .level     (level),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int sz;
        int hd;
        logic [31:0] exp_d;
        sz = q.size();
        hd = (sz != 0) ? q[0] : 0;
        exp_d = (sz != 0 && hd < 10) ? (32'd1 << hd) : 32'd0;
        chk("out_valid", {31'd0, out_valid}, (sz != 0) ? 32'd1 : 32'd0);
        chk("out_d",     {22'd0, out_d},     exp_d);
        chk("out_err",   {31'd0, out_err},   (sz != 0 && hd >= 10) ? 32'd1 : 32'd0);
        chk("level",     {29'd0, level},     sz);
        chk("in_ready",  {31'd0, in_ready},  (sz != DEPTH) ? 32'd1 : 32'd0);
        chk("err_count", {30'd0, err_count}, errc);
    endtask

    // One clock: drive inputs, advance reference at the edge, compare just after it.
    task automatic cycle(input logic v, input int bcd, input logic rdy, input logic rstn);
        bit do_push;
        bit do_pop;
        in_valid  = v;
        in_bcd    = 4'(bcd);
        out_ready = rdy;
        rst_n     = rstn;
        @(posedge clk);
        if (!rstn) begin
            q.delete();
            errc = 0;
        end else begin
            do_push = v && (q.size() != DEPTH);
            do_pop  = rdy && (q.size() != 0);
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back(bcd);
                if (bcd >= 10 && errc < err_max) errc++;
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        int d;
        in_valid  = 1'b0;
        in_bcd    = 4'd0;
        out_ready = 1'b0;
        rst_n     = 1'b0;

        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);

        for (int i = 0; i < 10; i++) cycle(1, i, 1, 1);
        cycle(0, 0, 1, 1);
        cycle(0, 0, 1, 1);

        cycle(1, 10, 1, 1);
        cycle(1, 15, 1, 1);
        cycle(1, 3, 1, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1);
        chk("err_count_two", {30'd0, err_count}, 32'd2);

        cycle(1, 7, 0, 1);
        cycle(1, 1, 0, 1);
        cycle(1, 4, 0, 1);
        cycle(1, 9, 0, 1);
        cycle(1, 2, 0, 1);
        cycle(1, 2, 0, 1);
        chk("full_level", {29'd0, level}, 32'd4);
        cycle(1, 2, 1, 1);
        cycle(1, 2, 1, 1);
        for (int i = 0; i < 6; i++) cycle(0, 0, 1, 1);

        cycle(1, 6, 0, 1);
        cycle(1, 8, 0, 1);
        for (int i = 0; i < 6; i++) cycle(1, $urandom_range(0, 9), 1, 1);
        chk("steady_level", {29'd0, level}, 32'd2);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 1);

        cycle(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, $urandom_range(10, 15), 1, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1);
        chk("err_sat", {30'd0, err_count}, 32'd3);

        cycle(1, 11, 0, 1);
        cycle(1, 4, 0, 1);
        cycle(1, 5, 0, 1);
        cycle(1, 8, 0, 0);
        chk("rst_level", {29'd0, level}, 32'd0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1);

        for (int i = 0; i < 400; i++) begin
            d = $urandom_range(0, 15);
            cycle(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 59) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
